// File: rtl/track_row_buffer.sv
// track_row_buffer: circular buffer of track rows for the pseudo-3D runner.
// The generator pushes rows through a valid/ready handshake. A retire pulse
// drops the oldest row. A two-stage lookup pipeline returns the tile code for
// a (lane, absolute row) pair.
// Optional macro TRB_STATS_EN: builds the saturating lookup-miss counter.
// With the macro undefined, stat_miss is tied to zero.
module track_row_buffer #(
    parameter int unsigned     ROWS      = 8,
    parameter int unsigned     TW        = 2,
    parameter logic [TW-1:0]   VOID_CODE = TW'(2'b11)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_valid,
    output logic                     push_ready,
    input  logic [5*TW-1:0]          push_row,
    input  logic                     retire,
    output logic [10:0]              base_row,
    output logic [$clog2(ROWS):0]    count,
    input  logic                     lk_valid,
    input  logic [2:0]               index_x,
    input  logic [10:0]              index_y,
    output logic [TW-1:0]            tile,
    output logic                     tile_valid,
    output logic [15:0]              stat_miss
);

    localparam int unsigned AW    = $clog2(ROWS);
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned RW    = 5 * TW;
    localparam int unsigned YW    = 11;
    localparam int unsigned LANES = 5;

    // Row storage, deliberately left uninitialised by reset
    logic [RW-1:0] mem [ROWS];

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    logic          push_acc_c;
    logic          retire_eff_c;

    // Stage-1 combinational terms
    logic [YW-1:0] off_c;
    logic          hit_c;
    logic [AW-1:0] slot_c;

    // Stage-1 registers
    logic          s1_valid;
    logic          s1_hit;
    logic [AW-1:0] s1_slot;
    logic [2:0]    s1_x;

    // Stage-2 read path
    logic [RW-1:0] rd_row_c;
    logic [TW-1:0] lane_c;

    // Space is judged from the registered count, so a full buffer stays
    // closed for one cycle even when a retire frees a slot.
    assign push_ready   = (count < CW'(ROWS));
    assign push_acc_c   = push_valid && push_ready;
    assign retire_eff_c = retire && (count != '0);

    // Pointers, occupancy and the absolute row number of the oldest row
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            base_row <= '0;
        end else begin
            if (push_acc_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (retire_eff_c) begin
                rd_ptr   <= rd_ptr + AW'(1);
                base_row <= base_row + YW'(1);
            end
            case ({push_acc_c, retire_eff_c})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Row write; reset blocks a push offered in the same cycle
    always_ff @(posedge clk) begin
        if (!rst && push_acc_c) begin
            mem[wr_ptr] <= push_row;
        end
    end

    // Window offset and hit decision against pre-update base_row/count.
    // The 11-bit subtraction wraps, so windows straddling row 2047 resolve.
    always_comb begin
        off_c  = index_y - base_row;
        hit_c  = lk_valid
                 && (index_x <= 3'd4)
                 && (index_y != 11'h7FF)
                 && (off_c < YW'(count));
        slot_c = rd_ptr + off_c[AW-1:0];
    end

    // Stage 1: register request, hit flag, physical slot and lane
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_hit   <= 1'b0;
            s1_slot  <= '0;
            s1_x     <= '0;
        end else begin
            s1_valid <= lk_valid;
            s1_hit   <= hit_c;
            s1_slot  <= slot_c;
            s1_x     <= index_x;
        end
    end

    // Lane select out of the addressed row
    always_comb begin
        rd_row_c = mem[s1_slot];
        lane_c   = VOID_CODE;
        for (int k = 0; k < LANES; k++) begin
            if (s1_x == 3'(k)) begin
                lane_c = rd_row_c[k*TW +: TW];
            end
        end
    end

    // Stage 2: registered tile result; misses return the void code
    always_ff @(posedge clk) begin
        if (rst) begin
            tile       <= VOID_CODE;
            tile_valid <= 1'b0;
        end else begin
            tile       <= s1_hit ? lane_c : VOID_CODE;
            tile_valid <= s1_valid;
        end
    end

`ifdef TRB_STATS_EN
    // Saturating count of valid lookups that missed, aligned with tile_valid
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_miss <= '0;
        end else if (s1_valid && !s1_hit && (stat_miss != 16'hFFFF)) begin
            stat_miss <= stat_miss + 16'd1;
        end
    end
`else
    assign stat_miss = '0;
`endif

endmodule

// File: tb/tb_track_row_buffer.sv
// Bench for track_row_buffer: directed scenarios plus randomized traffic,
// checked against a queue-based model of the held rows and the lookup latency.
module tb_track_row_buffer;

    localparam int          ROWS = 8;
    localparam logic [1:0]  VOID = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid;
    logic        push_ready;
    logic [9:0]  push_row;
    logic        retire;
    logic [10:0] base_row;
    logic [3:0]  count;
    logic        lk_valid;
    logic [2:0]  index_x;
    logic [10:0] index_y;
    logic [1:0]  tile;
    logic        tile_valid;
    logic [15:0] stat_miss;

    int checks = 0;
    int passed = 0;

    // Model state: held rows oldest-first, absolute row of the oldest
    logic [9:0]  mq[$];
    int          mbase;
    // Lookup in flight (one stage) and the expected visible outputs
    logic        p1_v, p1_h;
    logic [1:0]  p1_t;
    logic        e_v;
    logic [1:0]  e_t;
    logic [15:0] exp_miss;
    logic [15:0] want_stat;

    track_row_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .push_valid (push_valid),
        .push_ready (push_ready),
        .push_row   (push_row),
        .retire     (retire),
        .base_row   (base_row),
        .count      (count),
        .lk_valid   (lk_valid),
        .index_x    (index_x),
        .index_y    (index_y),
        .tile       (tile),
        .tile_valid (tile_valid),
        .stat_miss  (stat_miss)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        rst = 1'b0; push_valid = 1'b0; push_row = '0; retire = 1'b0;
        lk_valid = 1'b0; index_x = '0; index_y = '0;
    endtask

    // Advance one clock, moving the model in lockstep with the current inputs
    task automatic cycle();
        logic       nv, nh;
        logic [1:0] nt;
        logic [9:0] row;
        int         off;
        bit         pu, re;
        nv  = lk_valid;
        off = (int'(index_y) - mbase) & 2047;
        nh  = lk_valid && (index_x <= 3'd4) && (index_y != 11'h7FF) && (off < mq.size());
        nt  = VOID;
        if (nh) begin
            row = mq[off];
            nt  = row[index_x*2 +: 2];
        end
        pu = push_valid && (mq.size() < ROWS);
        re = retire && (mq.size() > 0);
        @(posedge clk);
        if (rst) begin
            mq.delete();
            mbase = 0;
            e_v = 1'b0; e_t = VOID;
            p1_v = 1'b0; p1_h = 1'b0; p1_t = VOID;
            exp_miss = '0;
        end else begin
            if (p1_v && !p1_h && exp_miss != 16'hFFFF) exp_miss = exp_miss + 16'd1;
            e_v = p1_v; e_t = p1_t;
            p1_v = nv; p1_h = nh; p1_t = nt;
            if (re) begin
                void'(mq.pop_front());
                mbase = (mbase + 1) % 2048;
            end
            if (pu) mq.push_back(push_row);
        end
`ifdef TRB_STATS_EN
        want_stat = exp_miss;
`else
        want_stat = '0;
`endif
        #1;
    endtask

    task automatic push_one(input logic [9:0] r);
        push_valid = 1'b1; push_row = r;
        cycle();
        push_valid = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (count !== 4'd0) $display("FAIL reset_count got %0d want 0", count); else passed++;
        checks++; if (base_row !== 11'd0) $display("FAIL reset_base got %0d want 0", base_row); else passed++;
        checks++; if (push_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", push_ready); else passed++;
        checks++; if (tile_valid !== 1'b0) $display("FAIL reset_tile_valid got %b want 0", tile_valid); else passed++;
        checks++; if (tile !== VOID) $display("FAIL reset_tile got %0d want %0d", tile, VOID); else passed++;
        checks++; if (stat_miss !== 16'd0) $display("FAIL reset_stat got %0d want 0", stat_miss); else passed++;
    endtask

    task automatic test_basic_lookup();
        logic [9:0] r;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            r = 10'($urandom);
            r[5:4] = 2'(i);
            push_one(r);
        end
        checks++; if (count !== 4'd3) $display("FAIL basic_count got %0d want 3", count); else passed++;
        checks++; if (base_row !== 11'd0) $display("FAIL basic_base got %0d want 0", base_row); else passed++;
        lk_valid = 1'b1; index_x = 3'd2; index_y = 11'd1;
        cycle();
        lk_valid = 1'b0;
        checks++; if (tile_valid !== 1'b0) $display("FAIL basic_early_valid got %b want 0", tile_valid); else passed++;
        cycle();
        checks++; if (tile_valid !== 1'b1) $display("FAIL basic_valid got %b want 1", tile_valid); else passed++;
        checks++; if (tile !== 2'd2) $display("FAIL basic_tile got %0d want 2", tile); else passed++;
        cycle();
        checks++; if (tile_valid !== 1'b0 || tile !== VOID) $display("FAIL basic_idle got v=%b t=%0d want v=0 t=%0d", tile_valid, tile, VOID); else passed++;
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < ROWS; i++) push_one(10'($urandom));
        checks++; if (push_ready !== 1'b0) $display("FAIL full_ready got %b want 0", push_ready); else passed++;
        checks++; if (count !== 4'd8) $display("FAIL full_count got %0d want 8", count); else passed++;
        push_valid = 1'b1; push_row = 10'($urandom);
        cycle();
        checks++; if (count !== 4'd8 || push_ready !== 1'b0) $display("FAIL full_holdoff got count=%0d ready=%b want 8/0", count, push_ready); else passed++;
        retire = 1'b1;
        cycle();
        retire = 1'b0;
        checks++; if (count !== 4'd7 || base_row !== 11'd1) $display("FAIL full_retire got count=%0d base=%0d want 7/1", count, base_row); else passed++;
        cycle();
        push_valid = 1'b0;
        checks++; if (count !== 4'd8 || base_row !== 11'd1) $display("FAIL full_late_push got count=%0d base=%0d want 8/1", count, base_row); else passed++;
        checks++; if (count !== 4'(mq.size())) $display("FAIL full_model_count got %0d want %0d", count, mq.size()); else passed++;
    endtask

    task automatic test_miss();
        logic [2:0]  xs [4];
        logic [10:0] ys [4];
        xs[0] = 3'd5; ys[0] = 11'd0;
        xs[1] = 3'd7; ys[1] = 11'd0;
        xs[2] = 3'd0; ys[2] = 11'h7FF;
        xs[3] = 3'd0; ys[3] = base_row + 11'(count);
        for (int i = 0; i < 6; i++) begin
            lk_valid = (i < 4);
            if (i < 4) begin index_x = xs[i]; index_y = ys[i]; end
            cycle();
            if (i >= 1 && i <= 4) begin
                checks++; if (tile_valid !== 1'b1 || tile !== VOID) $display("FAIL miss_%0d got v=%b t=%0d want v=1 t=%0d", i - 1, tile_valid, tile, VOID); else passed++;
            end
        end
        checks++; if (stat_miss !== want_stat) $display("FAIL miss_stat got %0d want %0d", stat_miss, want_stat); else passed++;
    endtask

    task automatic test_retire_coherence();
        logic [9:0] r0;
        do_reset();
        r0 = 10'($urandom); r0[3:2] = 2'b01;
        push_one(r0);
        for (int i = 0; i < 3; i++) push_one(10'($urandom));
        lk_valid = 1'b1; index_x = 3'd1; index_y = 11'd0; retire = 1'b1;
        cycle();
        retire = 1'b0;
        cycle();
        lk_valid = 1'b0;
        checks++; if (tile_valid !== 1'b1 || tile !== r0[3:2]) $display("FAIL coh_retired_row got v=%b t=%0d want v=1 t=%0d", tile_valid, tile, r0[3:2]); else passed++;
        cycle();
        checks++; if (tile_valid !== 1'b1 || tile !== VOID) $display("FAIL coh_after_retire got v=%b t=%0d want v=1 t=%0d", tile_valid, tile, VOID); else passed++;
        checks++; if (base_row !== 11'd1 || count !== 4'd3) $display("FAIL coh_state got base=%0d count=%0d want 1/3", base_row, count); else passed++;
    endtask

    task automatic test_wrap();
        logic [9:0]  rows [5];
        logic [2:0]  xs [4];
        logic [10:0] ys [4];
        logic [1:0]  want [4];
        do_reset();
        push_one(10'($urandom));
        push_valid = 1'b1; retire = 1'b1;
        for (int i = 0; i < 2045; i++) begin
            push_row = 10'($urandom);
            cycle();
        end
        push_valid = 1'b0; retire = 1'b0;
        rows[0] = mq[0];
        for (int i = 1; i < 5; i++) begin
            rows[i] = 10'($urandom);
            push_one(rows[i]);
        end
        checks++; if (base_row !== 11'd2045 || count !== 4'd5) $display("FAIL wrap_state got base=%0d count=%0d want 2045/5", base_row, count); else passed++;
        xs[0] = 3'(2'($urandom)); ys[0] = 11'd1;    want[0] = rows[4][xs[0]*2 +: 2];
        xs[1] = 3'd1;             ys[1] = 11'd2;    want[1] = VOID;
        xs[2] = 3'd4;             ys[2] = 11'h7FF;  want[2] = VOID;
        xs[3] = 3'd0;             ys[3] = 11'd0;    want[3] = rows[3][1:0];
        for (int i = 0; i < 6; i++) begin
            lk_valid = (i < 4);
            if (i < 4) begin index_x = xs[i]; index_y = ys[i]; end
            cycle();
            if (i >= 1 && i <= 4) begin
                checks++; if (tile_valid !== 1'b1 || tile !== want[i-1]) $display("FAIL wrap_lookup_%0d got v=%b t=%0d want v=1 t=%0d", i - 1, tile_valid, tile, want[i-1]); else passed++;
            end
        end
    endtask

    task automatic test_random();
        int mode;
        for (int n = 0; n < 600; n++) begin
            push_valid = ($urandom_range(0, 1) == 1);
            push_row   = 10'($urandom);
            retire     = ($urandom_range(0, 9) < 4);
            lk_valid   = ($urandom_range(0, 3) != 0);
            index_x    = 3'($urandom_range(0, 7));
            mode       = $urandom_range(0, 3);
            case (mode)
                0:       index_y = 11'(base_row + 11'($urandom_range(0, 9)));
                1:       index_y = 11'h7FF;
                2:       index_y = 11'($urandom);
                default: index_y = 11'(base_row - 11'd1);
            endcase
            cycle();
            checks++; if (tile_valid !== e_v || tile !== e_t) $display("FAIL rand_tile_%0d got v=%b t=%0d want v=%b t=%0d", n, tile_valid, tile, e_v, e_t); else passed++;
            checks++; if (count !== 4'(mq.size()) || base_row !== 11'(mbase)) $display("FAIL rand_state_%0d got count=%0d base=%0d want %0d/%0d", n, count, base_row, mq.size(), mbase); else passed++;
            checks++; if (push_ready !== (mq.size() < ROWS)) $display("FAIL rand_ready_%0d got %b want %b", n, push_ready, mq.size() < ROWS); else passed++;
            checks++; if (stat_miss !== want_stat) $display("FAIL rand_stat_%0d got %0d want %0d", n, stat_miss, want_stat); else passed++;
        end
        idle_inputs();
    endtask

    task automatic test_reset_midstream();
        idle_inputs();
        push_one(10'($urandom));
        push_one(10'($urandom));
        lk_valid = 1'b1; index_x = 3'd0; index_y = base_row;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checks++; if (tile_valid !== 1'b0 || tile !== VOID) $display("FAIL mid_rst_out1 got v=%b t=%0d want v=0 t=%0d", tile_valid, tile, VOID); else passed++;
        checks++; if (count !== 4'd0 || base_row !== 11'd0 || push_ready !== 1'b1) $display("FAIL mid_rst_state got count=%0d base=%0d ready=%b want 0/0/1", count, base_row, push_ready); else passed++;
        checks++; if (stat_miss !== 16'd0) $display("FAIL mid_rst_stat got %0d want 0", stat_miss); else passed++;
        lk_valid = 1'b0;
        cycle();
        checks++; if (tile_valid !== 1'b0) $display("FAIL mid_rst_out2 got v=%b want 0", tile_valid); else passed++;
    endtask

    initial begin
        mbase = 0; exp_miss = '0; want_stat = '0;
        p1_v = 1'b0; p1_h = 1'b0; p1_t = VOID; e_v = 1'b0; e_t = VOID;
        idle_inputs();
        #1;
        test_reset();
        test_basic_lookup();
        test_full();
        test_miss();
        test_retire_coherence();
        test_wrap();
        test_random();
        test_reset_midstream();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/track_row_buffer.md
Name: track_row_buffer

Overview:
- Circular buffer of track rows for the pseudo-3D runner renderer.
- Sits directly downstream of the pixel-to-track location mapper, which supplies per-pixel (index_x lane 0-4, index_y absolute row). This block returns the tile code at that lane and row.
- Rows are pushed by the track generator through a valid/ready handshake.
- A retire pulse drops the oldest row as the ball advances past it.

Parameters:
- ROWS, 8, row slots held; power of 2, minimum 2.
- TW, 2, tile code width in bits.
- VOID_CODE, 2'b11, tile code returned on any miss.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- push_valid  in  1  generator offers a row
- push_ready  out  1  buffer can accept a row
- push_row  in  5*TW  lane tiles; lane k at bits [k*TW +: TW]
- retire  in  1  one-cycle pulse: drop the oldest row
- base_row  out  11  absolute row number of the oldest held row
- count  out  log2(ROWS)+1  rows held
- lk_valid  in  1  lookup request valid
- index_x  in  3  lane; values 5-7 (incl. 3'b111 "outside") are a miss
- index_y  in  11  absolute row; 11'h7FF is a miss
- tile  out  TW  tile code result
- tile_valid  out  1  tile is valid this cycle
- stat_miss  out  16  miss counter; only live with the optional feature

Behaviour:
- Reset values, in effect the cycle after rst is high:
  - count=0, base_row=0, rd_ptr=0, wr_ptr=0.
  - tile=VOID_CODE, tile_valid=0, stat_miss=0.
  - push_ready=1.
  - Pipeline valids are cleared and any in-flight lookup is dropped.
  - Row storage is not cleared.
- rst has priority over every other input.
- push_ready = (count < ROWS), taken from registered count.
- A push is accepted when push_valid && push_ready:
  - push_row is written to slot wr_ptr.
  - wr_ptr advances modulo ROWS.
- A retire is effective when retire && count>0:
  - rd_ptr advances modulo ROWS.
  - base_row increments and wraps from 2047 to 0.
  - retire with count==0 is ignored.
- Push and retire in the same cycle: both occur and count is unchanged.
- When full, push_ready=0 even if retire is high that cycle; the push is taken the following cycle.
- count updates:
  - +1 on push only.
  - -1 on effective retire only.
  - Never exceeds ROWS; never underflows.
- Lookup pipeline, fixed latency 2:
  - Request in cycle N gives tile and tile_valid in cycle N+2.
  - Fully pipelined; a new lookup is accepted every cycle.
- Stage 1, registered in cycle N:
  - off = (index_y - base_row) mod 2048, using base_row and count as of cycle N (pre-update).
  - hit = lk_valid && index_x<=4 && index_y!=11'h7FF && off<count.
  - slot = (rd_ptr + off[log2(ROWS)-1:0]) mod ROWS.
  - index_x is registered.
- Stage 2:
  - Registered read of slot and lane.
  - tile = hit ? lane data : VOID_CODE.
  - tile_valid = stage-1 lk_valid.
- Coherence:
  - A hit slot cannot be overwritten between stage 1 and stage 2, because pushes target only wr_ptr, which lies outside the held window.
  - A row retired in cycle N+1 still returns its stored data for a lookup accepted in cycle N.
- When lk_valid=0: tile_valid=0 two cycles later and tile=VOID_CODE.
- All arithmetic is unsigned. The 11-bit subtraction wraps, so a window that straddles base_row wrap-around (e.g. base 2045, count 5) resolves correctly.

Optional Feature:
- Macro: TRB_STATS_EN.
- Defined:
  - stat_miss counts stage-2 cycles where tile_valid=1 and the lookup missed.
  - 16-bit counter, saturates at 16'hFFFF, cleared by rst.
- Undefined:
  - No counter logic is built.
  - stat_miss is tied to 0.

Test Plan:
- Reset, then push 3 rows with lane2 codes 1,2,3 -> count=3, base_row=0. Lookup (x=2,y=1) -> tile=2 in cycle N+2, tile_valid=1.
- Push 8 rows with ROWS=8 -> push_ready=0 after the 8th. A 9th push_valid is held off. Assert retire with the 9th still pending -> push accepted the next cycle, count=8, base_row=1.
- Lookups (x=5,y=0), (x=7,y=0), (x=0,y=2047), and (x=0,y=base_row+count) -> tile=VOID_CODE, tile_valid=1. With TRB_STATS_EN, stat_miss=4.
- Lookup (x=1,y=0) in cycle N with retire in cycle N, count=4 -> returns row 0 data. Repeating the lookup in cycle N+1 -> VOID_CODE, base_row=1.
- Advance base_row to 2045 with push/retire, then hold 5 rows -> lookup y=1 returns the 5th row's data, y=2 -> VOID_CODE.
- Assert rst mid-stream with lookups in flight -> tile_valid=0 in both following cycles, count=0, base_row=0, push_ready=1.
